gerenciador_jogada: RTL and testbench

GERENCIADOR_JOGADA -- requirements
Module: gerenciador_jogada

---
 rtl/gerenciador_jogada.sv | 193 +++++++++++++++++++
 tb/tb_gerenciador_jogada.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gerenciador_jogada.sv
// gerenciador_jogada -- tic-tac-toe move manager.
//
// Tracks whose turn it is, writes accepted moves into the 3x3 board and
// checks each accepted move for a win or a draw. A per-turn idle counter
// passes the turn to the other player when it expires.
//
// Ports:
//   clock      in   1   single clock, rising edge
//   reset      in   1   synchronous, active-low
//   iniciar    in   1   start / restart game (wins over jogar)
//   jogar      in   1   move request
//   posicao    in   4   target cell 0..8 row-major, 9..15 illegal
//   jogador    out  1   player to move (0 = player 1, 1 = player 2)
//   tabuleiro  out 18   board, cell i at [2i+1:2i]: 00 empty, 01 P1, 10 P2
//   aceita     out  1   one-cycle pulse, move accepted
//   rejeita    out  1   one-cycle pulse, move rejected
//   timeout    out  1   one-cycle pulse, turn expired
//   fim_jogo   out  1   high while the game is over
//   vencedor   out  2   00 none, 01 P1, 10 P2, 11 draw
//   db_estado  out  2   current state encoding
module gerenciador_jogada #(
    parameter int TIMEOUT_CICLOS = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic        jogar,
    input  logic [3:0]  posicao,
    output logic        jogador,
    output logic [17:0] tabuleiro,
    output logic        aceita,
    output logic        rejeita,
    output logic        timeout,
    output logic        fim_jogo,
    output logic [1:0]  vencedor,
    output logic [1:0]  db_estado
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        ESPERA   = 2'd1,
        VERIFICA = 2'd2,
        FIM      = 2'd3
    } estado_t;

    localparam logic [15:0] TERMINAL = 16'(TIMEOUT_CICLOS - 1);

    estado_t     estado_q, estado_d;
    logic [17:0] tabuleiro_q, tabuleiro_d;
    logic        jogador_q, jogador_d;
    logic        aceita_q, aceita_d;
    logic        rejeita_q, rejeita_d;
    logic        timeout_q, timeout_d;
    logic        fim_q, fim_d;
    logic [1:0]  vencedor_q, vencedor_d;
    logic [15:0] contador_q, contador_d;

    // True when any of the 8 lines is fully owned by the given code.
    function automatic logic temLinha(input logic [17:0] b, input logic [1:0] c);
        logic [8:0] dono;
        for (int i = 0; i < 9; i++) begin
            dono[i] = (b[2*i +: 2] == c);
        end
        return (dono[0] & dono[1] & dono[2]) | (dono[3] & dono[4] & dono[5]) |
               (dono[6] & dono[7] & dono[8]) | (dono[0] & dono[3] & dono[6]) |
               (dono[1] & dono[4] & dono[7]) | (dono[2] & dono[5] & dono[8]) |
               (dono[0] & dono[4] & dono[8]) | (dono[2] & dono[4] & dono[6]);
    endfunction

    logic [1:0] codigo;
    logic       celulaLivre;
    logic       cheio;
    logic       terminal;

    // Mover's cell code, emptiness of the addressed cell and full-board flag.
    // An out-of-range posicao never matches a cell, so it reads as occupied.
    always_comb begin
        codigo      = {jogador_q, ~jogador_q};
        celulaLivre = 1'b0;
        cheio       = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (posicao == 4'(i)) begin
                celulaLivre = (tabuleiro_q[2*i +: 2] == 2'b00);
            end
            if (tabuleiro_q[2*i +: 2] == 2'b00) begin
                cheio = 1'b0;
            end
        end
        terminal = (contador_q == TERMINAL);
    end

    // Next-state logic. A move at terminal count is processed instead of the
    // timeout; a rejected move at terminal count restarts the turn counter.
    always_comb begin
        estado_d    = estado_q;
        tabuleiro_d = tabuleiro_q;
        jogador_d   = jogador_q;
        fim_d       = fim_q;
        vencedor_d  = vencedor_q;
        contador_d  = contador_q;
        aceita_d    = 1'b0;
        rejeita_d   = 1'b0;
        timeout_d   = 1'b0;

        if (iniciar) begin
            estado_d    = ESPERA;
            tabuleiro_d = '0;
            jogador_d   = 1'b0;
            fim_d       = 1'b0;
            vencedor_d  = 2'b00;
            contador_d  = '0;
        end else begin
            case (estado_q)
                ESPERA: begin
                    if (jogar) begin
                        if (celulaLivre) begin
                            for (int i = 0; i < 9; i++) begin
                                if (posicao == 4'(i)) begin
                                    tabuleiro_d[2*i +: 2] = codigo;
                                end
                            end
                            aceita_d   = 1'b1;
                            contador_d = '0;
                            estado_d   = VERIFICA;
                        end else begin
                            rejeita_d  = 1'b1;
                            contador_d = terminal ? 16'd0 : contador_q + 16'd1;
                        end
                    end else if (terminal) begin
                        timeout_d  = 1'b1;
                        jogador_d  = ~jogador_q;
                        contador_d = '0;
                    end else begin
                        contador_d = contador_q + 16'd1;
                    end
                end
                VERIFICA: begin
                    // Win is tested before fullness so a 9th-move win is a win.
                    if (temLinha(tabuleiro_q, codigo)) begin
                        vencedor_d = codigo;
                        fim_d      = 1'b1;
                        estado_d   = FIM;
                    end else if (cheio) begin
                        vencedor_d = 2'b11;
                        fim_d      = 1'b1;
                        estado_d   = FIM;
                    end else begin
                        jogador_d  = ~jogador_q;
                        contador_d = '0;
                        estado_d   = ESPERA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q    <= OCIOSO;
            tabuleiro_q <= '0;
            jogador_q   <= 1'b0;
            aceita_q    <= 1'b0;
            rejeita_q   <= 1'b0;
            timeout_q   <= 1'b0;
            fim_q       <= 1'b0;
            vencedor_q  <= 2'b00;
            contador_q  <= '0;
        end else begin
            estado_q    <= estado_d;
            tabuleiro_q <= tabuleiro_d;
            jogador_q   <= jogador_d;
            aceita_q    <= aceita_d;
            rejeita_q   <= rejeita_d;
            timeout_q   <= timeout_d;
            fim_q       <= fim_d;
            vencedor_q  <= vencedor_d;
            contador_q  <= contador_d;
        end
    end

    assign jogador   = jogador_q;
    assign tabuleiro = tabuleiro_q;
    assign aceita    = aceita_q;
    assign rejeita   = rejeita_q;
    assign timeout   = timeout_q;
    assign fim_jogo  = fim_q;
    assign vencedor  = vencedor_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_gerenciador_jogada.sv
// Testbench for gerenciador_jogada with a short turn timeout (8 cycles).
// A game-level reference model (board array, turn, winner, phase, idle
// count) is advanced once per clock from the same inputs as the DUT.
module tb_gerenciador_jogada;

    localparam int T = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        iniciar = 1'b0;
    logic        jogar = 1'b0;
    logic [3:0]  posicao = 4'd0;
    logic        jogador;
    logic [17:0] tabuleiro;
    logic        aceita, rejeita, timeout, fim_jogo;
    logic [1:0]  vencedor, db_estado;

    int nCompared = 0;
    int nFail = 0;

    gerenciador_jogada #(.TIMEOUT_CICLOS(T)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogar(jogar),
        .posicao(posicao), .jogador(jogador), .tabuleiro(tabuleiro),
        .aceita(aceita), .rejeita(rejeita), .timeout(timeout),
        .fim_jogo(fim_jogo), .vencedor(vencedor), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    wire [27:0] dutObs = {tabuleiro, jogador, aceita, rejeita, timeout,
                          fim_jogo, vencedor, db_estado};

    // Reference model: phase 0 idle, 1 waiting for move, 2 checking, 3 over.
    int mBoard[9];
    int mPlayer, mWinner, mPhase, mCount;
    bit mOver, mAcc, mRej, mTo;
    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic bit hasWon(int who);
        for (int l = 0; l < 8; l++)
            if (mBoard[lines[l][0]] == who && mBoard[lines[l][1]] == who &&
                mBoard[lines[l][2]] == who) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit boardFull();
        for (int i = 0; i < 9; i++) if (mBoard[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void clearGame();
        for (int i = 0; i < 9; i++) mBoard[i] = 0;
        mPlayer = 0; mWinner = 0; mOver = 1'b0; mCount = 0;
    endfunction

    function automatic void modelStep(bit r, bit ini, bit jog, int pos);
        mAcc = 1'b0; mRej = 1'b0; mTo = 1'b0;
        if (!r) begin
            clearGame(); mPhase = 0;
        end else if (ini) begin
            clearGame(); mPhase = 1;
        end else if (mPhase == 1) begin
            if (jog) begin
                if (pos <= 8 && mBoard[pos] == 0) begin
                    mBoard[pos] = mPlayer + 1; mAcc = 1'b1; mPhase = 2; mCount = 0;
                end else begin
                    mRej = 1'b1;
                    mCount = (mCount == T - 1) ? 0 : mCount + 1;
                end
            end else if (mCount == T - 1) begin
                mTo = 1'b1; mPlayer = 1 - mPlayer; mCount = 0;
            end else begin
                mCount++;
            end
        end else if (mPhase == 2) begin
            if (hasWon(mPlayer + 1)) begin
                mWinner = mPlayer + 1; mOver = 1'b1; mPhase = 3;
            end else if (boardFull()) begin
                mWinner = 3; mOver = 1'b1; mPhase = 3;
            end else begin
                mPlayer = 1 - mPlayer; mPhase = 1; mCount = 0;
            end
        end
    endfunction

    function automatic logic [27:0] expObs();
        logic [17:0] b;
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(mBoard[i]);
        return {b, 1'(mPlayer), mAcc, mRej, mTo, mOver, 2'(mWinner), 2'(mPhase)};
    endfunction

    // Drives one cycle of inputs, advances the model, samples 1 ns after the edge.
    task automatic tick(input bit r, input bit ini, input bit jog, input int pos);
        reset = r; iniciar = ini; jogar = jog; posicao = 4'(pos);
        modelStep(r, ini, jog, pos);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 0);
        nCompared++;
        if (dutObs !== 28'd0) begin
            nFail++; $display("[TB] FAIL reset_state got %h want %h", dutObs, 28'd0);
        end
        tick(1, 0, 1, 0);
        nCompared++;
        if (dutObs !== expObs()) begin
            nFail++; $display("[TB] FAIL idle_ignores_jogar got %h want %h", dutObs, expObs());
        end
    endtask

    task automatic test_win_row();
        int seq[5] = '{0, 3, 1, 4, 2};
        tick(1, 1, 0, 0);
        foreach (seq[k]) begin
            tick(1, 0, 1, seq[k]);
            nCompared++;
            if (dutObs !== expObs() || aceita !== 1'b1) begin
                nFail++; $display("[TB] FAIL win_move%0d got %h want %h", k, dutObs, expObs());
            end
            tick(1, 0, 0, 0);
            nCompared++;
            if (dutObs !== expObs()) begin
                nFail++; $display("[TB] FAIL win_check%0d got %h want %h", k, dutObs, expObs());
            end
        end
        nCompared++;
        if (tabuleiro[5:0] !== 6'b010101 || vencedor !== 2'b01 || fim_jogo !== 1'b1 ||
            jogador !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL win_result got tab=%h venc=%b fim=%b jog=%b want cells0-2=01 venc=01 fim=1 jog=0",
                     tabuleiro, vencedor, fim_jogo, jogador);
        end
        tick(1, 0, 1, 5);
        nCompared++;
        if (dutObs !== expObs() || {aceita, rejeita, timeout} !== 3'b000) begin
            nFail++; $display("[TB] FAIL jogar_in_fim got %h want %h", dutObs, expObs());
        end
    endtask

    task automatic test_reject();
        tick(1, 1, 0, 0);
        tick(1, 0, 1, 4);
        tick(1, 0, 0, 0);
        tick(1, 0, 1, 4);
        nCompared++;
        if (dutObs !== expObs() || rejeita !== 1'b1) begin
            nFail++; $display("[TB] FAIL reject_occupied got %h want %h", dutObs, expObs());
        end
        tick(1, 0, 1, 12);
        nCompared++;
        if (dutObs !== expObs() || rejeita !== 1'b1) begin
            nFail++; $display("[TB] FAIL reject_range got %h want %h", dutObs, expObs());
        end
        nCompared++;
        if (tabuleiro !== 18'h00100 || jogador !== 1'b1) begin
            nFail++; $display("[TB] FAIL reject_board got tab=%h jog=%b want tab=00100 jog=1",
                              tabuleiro, jogador);
        end
    endtask

    task automatic test_draw();
        int seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        tick(1, 1, 0, 0);
        foreach (seq[k]) begin
            tick(1, 0, 1, seq[k]);
            nCompared++;
            if (dutObs !== expObs() || aceita !== 1'b1) begin
                nFail++; $display("[TB] FAIL draw_move%0d got %h want %h", k, dutObs, expObs());
            end
            tick(1, 0, 0, 0);
            nCompared++;
            if (dutObs !== expObs()) begin
                nFail++; $display("[TB] FAIL draw_check%0d got %h want %h", k, dutObs, expObs());
            end
        end
        nCompared++;
        if (vencedor !== 2'b11 || fim_jogo !== 1'b1) begin
            nFail++; $display("[TB] FAIL draw_result got venc=%b fim=%b want venc=11 fim=1",
                              vencedor, fim_jogo);
        end
    endtask

    task automatic test_timeout();
        tick(1, 1, 0, 0);
        for (int i = 1; i <= 2 * T; i++) begin
            tick(1, 0, 0, 0);
            nCompared++;
            if (dutObs !== expObs()) begin
                nFail++; $display("[TB] FAIL timeout_cycle%0d got %h want %h", i, dutObs, expObs());
            end
            if (i == T || i == 2 * T) begin
                nCompared++;
                if (timeout !== 1'b1 || jogador !== ((i == T) ? 1'b1 : 1'b0)) begin
                    nFail++; $display("[TB] FAIL timeout_pulse%0d got to=%b jog=%b want to=1 jog=%b",
                                      i, timeout, jogador, (i == T) ? 1'b1 : 1'b0);
                end
            end
        end
    endtask

    task automatic test_terminal_jogar();
        tick(1, 1, 0, 0);
        for (int i = 1; i < T; i++) tick(1, 0, 0, 0);
        tick(1, 0, 1, 12);
        nCompared++;
        if (dutObs !== expObs() || rejeita !== 1'b1 || timeout !== 1'b0) begin
            nFail++; $display("[TB] FAIL terminal_reject got %h want %h", dutObs, expObs());
        end
        for (int i = 1; i <= T; i++) begin
            tick(1, 0, 0, 0);
            nCompared++;
            if (dutObs !== expObs() || timeout !== ((i == T) ? 1'b1 : 1'b0)) begin
                nFail++; $display("[TB] FAIL terminal_after%0d got %h want %h", i, dutObs, expObs());
            end
        end
    endtask

    task automatic test_iniciar_priority();
        tick(1, 1, 0, 0);
        tick(1, 0, 1, 0);
        tick(1, 0, 0, 0);
        tick(1, 1, 1, 3);
        nCompared++;
        if (tabuleiro !== 18'd0 || aceita !== 1'b0 || dutObs !== expObs()) begin
            nFail++; $display("[TB] FAIL iniciar_priority got %h want %h", dutObs, expObs());
        end
    endtask

    task automatic test_reset_verifica();
        tick(1, 1, 0, 0);
        tick(1, 0, 1, 2);
        tick(0, 0, 0, 0);
        nCompared++;
        if (dutObs !== 28'd0) begin
            nFail++; $display("[TB] FAIL reset_in_verifica got %h want %h", dutObs, 28'd0);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 1, i);
            nCompared++;
            if (dutObs !== 28'd0) begin
                nFail++; $display("[TB] FAIL idle_after_reset%0d got %h want %h", i, dutObs, 28'd0);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 63) != 0), ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 2) == 0), int'($urandom_range(0, 15)));
            nCompared++;
            if (dutObs !== expObs() || (32'(aceita) + 32'(rejeita) + 32'(timeout)) > 1) begin
                nFail++; $display("[TB] FAIL random_cycle%0d got %h want %h", i, dutObs, expObs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_win_row();
        test_reject();
        test_draw();
        test_timeout();
        test_terminal_jogar();
        test_iniciar_priority();
        test_reset_verifica();
        tick(1, 1, 0, 0);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFail);
        $finish;
    end

endmodule
